dcompressor_sched: RTL

//  Time-multiplexes one dcompressor datapath across NCH sample channels. Round-robin

---
 rtl/dcompressor_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/dcompressor_sched.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dcompressor_pkg.sv
// Shared types and reset defaults for the dcompressor channel scheduler.
package dcompressor_pkg;

  localparam int unsigned RATIO_W = 3;

  localparam logic [7:0]         DEF_THRESH = 8'h60;
  localparam logic [RATIO_W-1:0] DEF_RATIO  = 3'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    APPLY = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requesting channel at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] ptr,
  output logic [NCH-1:0]         grant,
  output logic [$clog2(NCH)-1:0] idx,
  output logic                   any
);
  import dcompressor_pkg::*;

  localparam int unsigned PW = $clog2(NCH);

  logic [PW-1:0] k;

  // Scan channels starting at ptr; the first requester wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      k = PW'((32'(ptr) + i) % NCH);
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/dcompressor_sched.sv
// Time-multiplexes one fixed-latency compressor across NCH channels, re-tagging
// results with their source channel and applying config changes only when drained.
module dcompressor_sched #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned CMP_LAT = 1,
  parameter logic [DW-1:0] DEF_THRESH = dcompressor_pkg::DEF_THRESH,
  parameter logic [dcompressor_pkg::RATIO_W-1:0] DEF_RATIO = dcompressor_pkg::DEF_RATIO
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_enable,
  input  logic [NCH-1:0]                      i_ch_valid,
  input  logic [NCH*DW-1:0]                   i_ch_data,
  output logic [NCH-1:0]                      o_ch_ready,
  output logic                                o_cmp_valid,
  output logic [DW-1:0]                       o_cmp_data,
  input  logic [DW-1:0]                       i_cmp_data,
  output logic [DW-1:0]                       o_cmp_thresh,
  output logic [dcompressor_pkg::RATIO_W-1:0] o_cmp_ratio,
  input  logic                                i_cfg_we,
  input  logic [DW-1:0]                       i_cfg_thresh,
  input  logic [dcompressor_pkg::RATIO_W-1:0] i_cfg_ratio,
  output logic                                o_out_valid,
  output logic [DW-1:0]                       o_out_data,
  output logic [$clog2(NCH)-1:0]              o_out_ch,
  output logic                                o_busy
);
  import dcompressor_pkg::*;

  localparam int unsigned PW = $clog2(NCH);
  localparam int unsigned IW = $clog2(CMP_LAT + 3);

  state_t               state;
  logic [PW-1:0]        rr_ptr;
  logic [IW-1:0]        inflight;
  logic                 pending;
  logic [DW-1:0]        shadow_thresh;
  logic [RATIO_W-1:0]   shadow_ratio;

  logic [NCH-1:0]       arb_grant;
  logic [PW-1:0]        arb_idx;
  logic                 arb_any;
  logic                 issue_ok;
  logic                 xfer;

  logic [PW-1:0]        cmp_ch;
  logic                 tag_v  [CMP_LAT];
  logic [PW-1:0]        tag_ch [CMP_LAT];

  // Grants are withheld as soon as a config write is pending or enable drops,
  // so no sample is issued in the cycle the FSM is already heading to DRAIN.
  assign issue_ok = (state == ISSUE) && i_enable && !pending;
  assign xfer     = issue_ok && arb_any;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req   (i_ch_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign o_ch_ready = issue_ok ? arb_grant : '0;
  assign o_busy     = (state != IDLE) || (inflight != '0);

  // Scheduler FSM plus shadow/active compressor configuration.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      pending       <= 1'b0;
      shadow_thresh <= DEF_THRESH;
      shadow_ratio  <= DEF_RATIO;
      o_cmp_thresh  <= DEF_THRESH;
      o_cmp_ratio   <= DEF_RATIO;
    end else begin
      case (state)
        IDLE:  if (i_enable) state <= ISSUE;
        ISSUE: if (pending || !i_enable) state <= DRAIN;
        DRAIN: begin
          if (inflight == '0) begin
            if (pending)       state <= APPLY;
            else if (i_enable) state <= ISSUE;
            else               state <= IDLE;
          end
        end
        APPLY: begin
          o_cmp_thresh <= shadow_thresh;
          o_cmp_ratio  <= shadow_ratio;
          pending      <= 1'b0;
          state        <= i_enable ? ISSUE : IDLE;
        end
        default: state <= IDLE;
      endcase
      // A write landing in APPLY overrides the clear above and re-arms pending.
      if (i_cfg_we) begin
        shadow_thresh <= i_cfg_thresh;
        shadow_ratio  <= i_cfg_ratio;
        pending       <= 1'b1;
      end
    end
  end

  // Round-robin pointer and in-flight sample counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rr_ptr   <= '0;
      inflight <= '0;
    end else begin
      if (xfer) rr_ptr <= (arb_idx == PW'(NCH - 1)) ? '0 : arb_idx + 1'b1;
      case ({xfer, o_out_valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Issue register, channel-tag pipe aligned to compressor latency, result register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_cmp_valid <= 1'b0;
      o_cmp_data  <= '0;
      cmp_ch      <= '0;
      for (int unsigned s = 0; s < CMP_LAT; s++) begin
        tag_v[s]  <= 1'b0;
        tag_ch[s] <= '0;
      end
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_ch    <= '0;
    end else begin
      o_cmp_valid <= xfer;
      if (xfer) begin
        o_cmp_data <= i_ch_data[arb_idx*DW +: DW];
        cmp_ch     <= arb_idx;
      end
      tag_v[0]  <= o_cmp_valid;
      tag_ch[0] <= cmp_ch;
      for (int unsigned s = 1; s < CMP_LAT; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_ch[s] <= tag_ch[s-1];
      end
      o_out_valid <= tag_v[CMP_LAT-1];
      if (tag_v[CMP_LAT-1]) begin
        o_out_data <= i_cmp_data;
        o_out_ch   <= tag_ch[CMP_LAT-1];
      end
    end
  end

endmodule
